// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcode and data word, plus the arbiter state type used by alu_arbiter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL,
    ALU_SRL,
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU
  } aluop_t;

  // Arbiter ownership state; the lock owner index is held separately.
  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arb_state_t;

  localparam int unsigned ARB_NREQ_MAX = 4;

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between the ALU and whoever drives it.
//   port_A, port_B, aluop       : operands and opcode into the ALU
//   output_port, negative,
//   overflow, zero              : combinational result and flags out of the ALU
interface alu_if;
  import cpu_types_pkg::*;

  word_t  port_A;
  word_t  port_B;
  aluop_t aluop;
  word_t  output_port;
  logic   negative;
  logic   overflow;
  logic   zero;

  modport alu (
    input  port_A, port_B, aluop,
    output output_port, negative, overflow, zero
  );

  modport drv (
    output port_A, port_B, aluop,
    input  output_port, negative, overflow, zero
  );

endinterface

// File: rtl/alu.sv
// Single-cycle combinational ALU.
//   aluif (alu modport): operands/opcode in, result and negative/overflow/zero flags out.
// Overflow is only meaningful for ADD/SUB (signed); it reads 0 for every other opcode.
module alu (
  alu_if.alu aluif
);
  import cpu_types_pkg::*;

  word_t a;
  word_t b;
  word_t res;
  logic  ovf;

  assign a = aluif.port_A;
  assign b = aluif.port_B;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    unique case (aluif.aluop)
      ALU_SLL:  res = a << b[4:0];
      ALU_SRL:  res = a >> b[4:0];
      ALU_ADD: begin
        res = a + b;
        ovf = (a[31] == b[31]) && (res[31] != a[31]);
      end
      ALU_SUB: begin
        res = a - b;
        ovf = (a[31] != b[31]) && (res[31] != a[31]);
      end
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_NOR:  res = ~(a | b);
      ALU_SLT:  res = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: res = {31'd0, a < b};
      default:  res = '0;
    endcase
  end

  assign aluif.output_port = res;
  assign aluif.negative    = res[31];
  assign aluif.overflow    = ovf;
  assign aluif.zero        = (res == '0);

endmodule

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req_i    : request vector
//   rr_ptr_i : highest-priority index this cycle; priority falls off in increasing index, wrapping
//   gnt_o    : one-hot winner (zero when no request)
//   idx_o    : encoded winner index
//   valid_o  : a winner exists
module rr_picker #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PtrW = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PtrW-1:0] rr_ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PtrW-1:0] idx_o,
  output logic            valid_o
);

  int unsigned     pos;
  logic [NREQ-1:0] sel;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      pos = (32'(rr_ptr_i) + k) % NREQ;
      sel = NREQ'(1) << pos;
      if (!valid_o && |(req_i & sel)) begin
        valid_o = 1'b1;
        idx_o   = PtrW'(pos);
        gnt_o   = sel;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ (2..4) requesters.
//   CLK, nRST          : clock, asynchronous active-low reset
//   req, lock          : per-requester request and keep-ownership request
//   aluop/port_a/port_b: per-requester opcode and operands
//   gnt                : combinational one-hot grant (or zero)
//   rsp_valid          : registered one-cycle pulse to the requester granted last cycle
//   rsp_data/neg/ovf/zero: registered ALU result and flags of the last grant (held otherwise)
//   busy               : registered, high while a lock owner exists
module alu_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] lock,
  input  aluop_t          aluop  [NREQ],
  input  word_t           port_a [NREQ],
  input  word_t           port_b [NREQ],
  output logic [NREQ-1:0] gnt,
  output logic [NREQ-1:0] rsp_valid,
  output word_t           rsp_data,
  output logic            rsp_neg,
  output logic            rsp_ovf,
  output logic            rsp_zero,
  output logic            busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef logic [PtrW-1:0] ptr_t;

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(NREQ - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  arb_state_t      state_q, state_d;
  ptr_t            owner_q, owner_d;
  ptr_t            rr_ptr_q, rr_ptr_d;
  logic            busy_q, busy_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  word_t           rsp_data_q, rsp_data_d;
  logic            rsp_neg_q, rsp_neg_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            rsp_zero_q, rsp_zero_d;

  logic [NREQ-1:0] pick_gnt;
  ptr_t            pick_idx;
  logic            pick_valid;

  ptr_t            grant_idx;
  logic            grant_valid;

  aluop_t          mux_op;
  word_t           mux_a;
  word_t           mux_b;

  alu_if aluif ();

  alu u_alu (
    .aluif (aluif)
  );

  rr_picker #(
    .NREQ (NREQ),
    .PtrW (PtrW)
  ) u_picker (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  // Arbitration and lock tracking.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    gnt         = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    unique case (state_q)
      ARB_FREE: begin
        gnt         = pick_gnt;
        grant_idx   = pick_idx;
        grant_valid = pick_valid;
        if (pick_valid) begin
          rr_ptr_d = ptr_inc(pick_idx);
          if (lock[pick_idx]) begin
            state_d = ARB_LOCKED;
            owner_d = pick_idx;
          end
        end
      end
      ARB_LOCKED: begin
        // Only the owner may be served; others wait even if the owner idles this cycle.
        grant_idx   = owner_q;
        grant_valid = req[owner_q];
        gnt         = grant_valid ? (NREQ'(1) << owner_q) : '0;
        if (!lock[owner_q]) begin
          state_d = ARB_FREE;
        end
      end
      default: state_d = ARB_FREE;
    endcase
  end

  // Operand steering; idle ALU sees a harmless SLL 0,0.
  always_comb begin
    mux_op = ALU_SLL;
    mux_a  = '0;
    mux_b  = '0;
    if (grant_valid) begin
      mux_op = aluop[grant_idx];
      mux_a  = port_a[grant_idx];
      mux_b  = port_b[grant_idx];
    end
  end

  assign aluif.aluop  = mux_op;
  assign aluif.port_A = mux_a;
  assign aluif.port_B = mux_b;

  // Response capture: data and flags hold across idle cycles.
  always_comb begin
    rsp_valid_d = grant_valid ? (NREQ'(1) << grant_idx) : '0;
    rsp_data_d  = grant_valid ? aluif.output_port : rsp_data_q;
    rsp_neg_d   = grant_valid ? aluif.negative    : rsp_neg_q;
    rsp_ovf_d   = grant_valid ? aluif.overflow    : rsp_ovf_q;
    rsp_zero_d  = grant_valid ? aluif.zero        : rsp_zero_q;
    busy_d      = (state_d == ARB_LOCKED);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= ARB_FREE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_neg_q   <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_neg_q   <= rsp_neg_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_zero_q  <= rsp_zero_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_neg   = rsp_neg_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_zero  = rsp_zero_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one NREQ=2 and one NREQ=4 instance, directed steps then random traffic,
// every cycle compared against a behavioural model of the arbitration rules and ALU arithmetic.
module tb_alu_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] req_v  [2];
  logic [3:0] lock_v [2];
  aluop_t     op_v   [2][4];
  word_t      a_v    [2][4];
  word_t      b_v    [2][4];

  aluop_t op2 [2];
  word_t  a2  [2];
  word_t  b2  [2];
  aluop_t op4 [4];
  word_t  a4  [4];
  word_t  b4  [4];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      op2[i] = op_v[0][i];
      a2[i]  = a_v[0][i];
      b2[i]  = b_v[0][i];
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      op4[i] = op_v[1][i];
      a4[i]  = a_v[1][i];
      b4[i]  = b_v[1][i];
    end
  end

  logic [1:0] gnt2, rv2;
  logic [3:0] gnt4, rv4;
  word_t      d2, d4;
  logic       n2, v2, z2, bz2, n4, v4, z4, bz4;

  alu_arbiter #(.NREQ(2)) u_dut2 (
    .CLK       (clk),
    .nRST      (rst_n),
    .req       (req_v[0][1:0]),
    .lock      (lock_v[0][1:0]),
    .aluop     (op2),
    .port_a    (a2),
    .port_b    (b2),
    .gnt       (gnt2),
    .rsp_valid (rv2),
    .rsp_data  (d2),
    .rsp_neg   (n2),
    .rsp_ovf   (v2),
    .rsp_zero  (z2),
    .busy      (bz2)
  );

  alu_arbiter #(.NREQ(4)) u_dut4 (
    .CLK       (clk),
    .nRST      (rst_n),
    .req       (req_v[1]),
    .lock      (lock_v[1]),
    .aluop     (op4),
    .port_a    (a4),
    .port_b    (b4),
    .gnt       (gnt4),
    .rsp_valid (rv4),
    .rsp_data  (d4),
    .rsp_neg   (n4),
    .rsp_ovf   (v4),
    .rsp_zero  (z4),
    .busy      (bz4)
  );

  int checks = 0;
  int errors = 0;

  // Model state per instance.
  int         nq [2] = '{2, 4};
  bit         m_lk   [2];
  int         m_own  [2];
  int         m_ptr  [2];
  logic [3:0] m_rv   [2];
  word_t      m_d    [2];
  logic       m_n    [2];
  logic       m_v    [2];
  logic       m_z    [2];
  logic       m_busy [2];
  int         last_g [2];
  logic [3:0] obs_g  [2];

  localparam longint MaxS = 64'sd2147483647;
  localparam longint MinS = -64'sd2147483648;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_alu(input aluop_t op, input word_t a, input word_t b,
                                  output word_t r, output logic n, output logic v,
                                  output logic z);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s  = 0;
    v  = 1'b0;
    case (op)
      ALU_SLL:  r = a << b[4:0];
      ALU_SRL:  r = a >> b[4:0];
      ALU_ADD: begin s = sa + sb; r = s[31:0]; v = (s > MaxS) || (s < MinS); end
      ALU_SUB: begin s = sa - sb; r = s[31:0]; v = (s > MaxS) || (s < MinS); end
      ALU_AND:  r = a & b;
      ALU_OR:   r = a | b;
      ALU_XOR:  r = a ^ b;
      ALU_NOR:  r = ~(a | b);
      ALU_SLT:  r = (sa < sb) ? 32'd1 : 32'd0;
      ALU_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      default:  r = 32'd0;
    endcase
    n = r[31];
    z = (r == 32'd0);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_lk[d] = 1'b0; m_own[d] = 0; m_ptr[d] = 0; m_rv[d] = '0; m_d[d] = '0;
      m_n[d] = 1'b0; m_v[d] = 1'b0; m_z[d] = 1'b0; m_busy[d] = 1'b0; last_g[d] = -1;
    end
  endtask

  // Compare one instance against the model for the current cycle, then advance the model.
  task automatic check_dut(input int d);
    logic [3:0] og, orv;
    word_t      od, r;
    logic       on, ov, oz, ob, rn, rvf, rz;
    int         g, i;
    string      p;
    if (d == 0) begin
      og = {2'b00, gnt2}; orv = {2'b00, rv2}; od = d2; on = n2; ov = v2; oz = z2; ob = bz2;
    end else begin
      og = gnt4; orv = rv4; od = d4; on = n4; ov = v4; oz = z4; ob = bz4;
    end
    obs_g[d] = og;
    g = -1;
    if (m_lk[d]) begin
      if (req_v[d][m_own[d]]) g = m_own[d];
    end else begin
      for (int k = 0; k < nq[d]; k++) begin
        i = (m_ptr[d] + k) % nq[d];
        if (g < 0 && req_v[d][i]) g = i;
      end
    end
    p = $sformatf("n%0d", nq[d]);
    chk({p, "_gnt"}, 32'(og), (g >= 0) ? 32'(1 << g) : 32'd0);
    chk({p, "_rsp_valid"}, 32'(orv), 32'(m_rv[d]));
    chk({p, "_rsp_data"}, od, m_d[d]);
    chk({p, "_flags"}, {29'd0, on, ov, oz}, {29'd0, m_n[d], m_v[d], m_z[d]});
    chk({p, "_busy"}, 32'(ob), 32'(m_busy[d]));
    if (g >= 0) begin
      ref_alu(op_v[d][g], a_v[d][g], b_v[d][g], r, rn, rvf, rz);
      m_rv[d] = 4'(1 << g); m_d[d] = r; m_n[d] = rn; m_v[d] = rvf; m_z[d] = rz;
    end else begin
      m_rv[d] = '0;
    end
    if (m_lk[d]) begin
      if (!lock_v[d][m_own[d]]) m_lk[d] = 1'b0;
    end else if (g >= 0) begin
      m_ptr[d] = (g + 1) % nq[d];
      if (lock_v[d][g]) begin
        m_lk[d]  = 1'b1;
        m_own[d] = g;
      end
    end
    m_busy[d] = m_lk[d];
    last_g[d] = g;
  endtask

  task automatic cyc();
    @(negedge clk);
    check_dut(0);
    check_dut(1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int d, input int i, input aluop_t op, input word_t a,
                         input word_t b, input logic lk);
    req_v[d][i] = 1'b1; lock_v[d][i] = lk; op_v[d][i] = op; a_v[d][i] = a; b_v[d][i] = b;
  endtask

  task automatic drop(input int d, input int i);
    req_v[d][i] = 1'b0; lock_v[d][i] = 1'b0;
  endtask

  task automatic clear_all();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        drop(d, i); op_v[d][i] = ALU_SLL; a_v[d][i] = '0; b_v[d][i] = '0;
      end
    end
  endtask

  initial begin
    clear_all();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc();                       // reset values
    rst_n = 1'b1;

    // ADD 3,4 on requester 0.
    set_req(0, 0, ALU_ADD, 32'd3, 32'd4, 1'b0);
    cyc();
    chk("add_gnt", 32'(obs_g[0]), 32'd1);
    drop(0, 0);
    chk("add_rsp_valid", 32'(rv2), 32'd1);
    chk("add_rsp_data", d2, 32'd7);
    chk("add_rsp_zero", 32'(z2), 32'd0);

    // SUB 5,5 then OR 0,8 on requester 1.
    set_req(0, 1, ALU_SUB, 32'd5, 32'd5, 1'b0);
    cyc();
    drop(0, 1);
    chk("sub_rsp_data", d2, 32'd0);
    chk("sub_rsp_zero", 32'(z2), 32'd1);
    set_req(0, 1, ALU_OR, 32'd0, 32'd8, 1'b0);
    cyc();
    drop(0, 1);
    chk("or_rsp_data", d2, 32'd8);
    chk("or_rsp_zero", 32'(z2), 32'd0);

    // Both held, pointer at 0: grants alternate 0,1,0,1.
    set_req(0, 0, ALU_ADD, 32'd1, 32'd1, 1'b0);
    set_req(0, 1, ALU_ADD, 32'd2, 32'd2, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("alt_gnt", 32'(obs_g[0]), (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_rsp_valid", 32'(rv2), (k % 2 == 0) ? 32'd1 : 32'd2);
    end
    drop(0, 0);
    drop(0, 1);

    // Move pointer to 1, then requester 1 locks for three grants while 0 waits.
    set_req(0, 0, ALU_XOR, 32'hF0F0, 32'h0FF0, 1'b0);
    cyc();
    set_req(0, 1, ALU_ADD, 32'd10, 32'd20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      if (k == 2) lock_v[0][1] = 1'b0;
      cyc();
      chk("lock_gnt", 32'(obs_g[0]), 32'd2);
      chk("lock_busy", 32'(bz2), (k < 2) ? 32'd1 : 32'd0);
    end
    drop(0, 1);
    cyc();
    chk("release_gnt", 32'(obs_g[0]), 32'd1);
    drop(0, 0);

    // Reset while a response is in flight; pointer returns to 0.
    set_req(0, 0, ALU_ADD, 32'd1, 32'd2, 1'b0);
    cyc();
    drop(0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rsp_valid", 32'(rv2), 32'd0);
    chk("rst_rsp_data", d2, 32'd0);
    cyc();
    rst_n = 1'b1;
    set_req(0, 0, ALU_AND, 32'hFF, 32'h0F, 1'b0);
    set_req(0, 1, ALU_AND, 32'hFF, 32'hF0, 1'b0);
    cyc();
    chk("rst_ptr_gnt", 32'(obs_g[0]), 32'd1);
    drop(0, 0);
    drop(0, 1);

    // Four requesters: move pointer to 3, then all request; order 3,0,1,2.
    set_req(1, 2, ALU_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cyc();
    drop(1, 2);
    for (int i = 0; i < 4; i++) set_req(1, i, ALU_ADD, 32'(i), 32'd100, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("wrap_gnt", 32'(obs_g[1]), 32'(1 << ((3 + k) % 4)));
    end
    for (int i = 0; i < 4; i++) drop(1, i);

    // Random traffic on both instances; requests persist until granted.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        for (int i = 0; i < nq[d]; i++) begin
          if (!req_v[d][i] && ($urandom % 2 == 0)) begin
            set_req(d, i, aluop_t'($urandom_range(0, 9)),
                    ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom),
                    ($urandom % 4 == 0) ? 32'($urandom % 16) : 32'($urandom), 1'b0);
            if ($urandom % 5 == 0) b_v[d][i] = a_v[d][i];
          end
          lock_v[d][i] = ($urandom % 3 == 0);
        end
      end
      cyc();
      for (int d = 0; d < 2; d++) begin
        if (last_g[d] >= 0) req_v[d][last_g[d]] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
